// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and defaults for the PLL lock sequencer: state encoding,
// default timing constants, blink divider exponents and a saturating counter helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam int DEF_RESET_CYCLES  = 27;
  localparam int DEF_LOCK_TIMEOUT  = 270_000;
  localparam int DEF_STABLE_CYCLES = 2_700;
  localparam int DEF_MAX_RETRIES   = 7;

  localparam int BLINK_CNT_W    = 24;
  localparam int BLINK_SLOW_EXP = 22;
  localparam int BLINK_FAST_EXP = 20;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Status/control bundle between the PLL lock sequencer (master) and its observer (slave).
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       pll_reset;
  logic       domain_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;
  logic [2:0] state;
  logic       led;

  modport master (
    input  pll_locked,
    output pll_reset, domain_reset, ready, fault, retry_count, loss_count, state, led
  );

  modport slave (
    output pll_locked,
    input  pll_reset, domain_reset, ready, fault, retry_count, loss_count, state, led
  );
endinterface

// File: rtl/pll_lock_sequencer_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture stages to settle metastability.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up supervisor: reset pulse, lock wait with timeout/retry, stability
// qualification, run monitoring and sticky fault. LED blinker: PLL_LOCK_SEQUENCER_LED_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int SLOW_EXP      = BLINK_SLOW_EXP,
  parameter int FAST_EXP      = BLINK_FAST_EXP
) (
  input  logic                 ext_clk,
  input  logic                 reset,
  pll_lock_sequencer_if.master seq_if
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [2:0] S_PLL_RST   = PLL_RST;
  localparam logic [2:0] S_WAIT_LOCK = WAIT_LOCK;
  localparam logic [2:0] S_STABLE    = STABLE;
  localparam logic [2:0] S_RUN       = RUN;
  localparam logic [2:0] S_FAULT     = FAULT;

  localparam logic [CW-1:0] RST_LOAD = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LOAD = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

  logic          lock_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_reset_q, domain_reset_q, ready_q, fault_q;

  sync2 u_lock_sync (
    .clk_i (ext_clk),
    .rst_i (reset),
    .d_i   (seq_if.pll_locked),
    .q_o   (lock_s)
  );

  // Next-state, counter reload and retry/loss bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TO_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = STB_LOAD;
        end else if (cnt_q == '0) begin
          retry_d = retry_q + 4'd1;
          cnt_d   = RST_LOAD;
          if (retry_d == MAX_R) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_PLL_RST;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STABLE: begin
        // A lock drop outranks a simultaneous expiry.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TO_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
          retry_d = 4'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
          cnt_d   = RST_LOAD;
          loss_d  = sat_inc8(loss_q);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  // State, counters and output decode registers.
  always_ff @(posedge ext_clk) begin
    if (reset) begin
      state_q        <= S_PLL_RST;
      cnt_q          <= RST_LOAD;
      retry_q        <= 4'd0;
      loss_q         <= 8'd0;
      pll_reset_q    <= 1'b1;
      domain_reset_q <= 1'b1;
      ready_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      loss_q         <= loss_d;
      pll_reset_q    <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
      domain_reset_q <= (state_d != S_RUN);
      ready_q        <= (state_d == S_RUN);
      fault_q        <= (state_d == S_FAULT);
    end
  end

`ifdef PLL_LOCK_SEQUENCER_LED_EN
  logic [BLINK_CNT_W-1:0] blink_q, blink_d;
  logic                   led_q, led_d;

  // Blink pattern selected by the upcoming state so the LED stays aligned with it.
  always_comb begin
    blink_d = blink_q + BLINK_CNT_W'(1);
    case (state_d)
      S_RUN:   led_d = 1'b0;
      S_FAULT: led_d = ~blink_d[FAST_EXP];
      default: led_d = ~blink_d[SLOW_EXP];
    endcase
  end

  // Free-running blink divider and registered LED.
  always_ff @(posedge ext_clk) begin
    if (reset) begin
      blink_q <= '0;
      led_q   <= 1'b1;
    end else begin
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign seq_if.led = led_q;
`else
  localparam int unused_blink_exps = SLOW_EXP + FAST_EXP;
  assign seq_if.led = 1'b1;
`endif

  assign seq_if.pll_reset    = pll_reset_q;
  assign seq_if.domain_reset = domain_reset_q;
  assign seq_if.ready        = ready_q;
  assign seq_if.fault        = fault_q;
  assign seq_if.retry_count  = retry_q;
  assign seq_if.loss_count   = loss_q;
  assign seq_if.state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing (4/20/8/2) and blink exponents of 3.
module tb_pll_lock_sequencer;

  logic ext_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;

  pll_lock_sequencer_if seq_if ();

  pll_lock_sequencer #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .SLOW_EXP      (3),
    .FAST_EXP      (3)
  ) u_dut (
    .ext_clk (ext_clk),
    .reset   (reset),
    .seq_if  (seq_if)
  );

  always #5 ext_clk = ~ext_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ext_clk);
      #1;
    end
  endtask

  task automatic check_reset_state();
    check("rst_pll_reset", 32'(seq_if.pll_reset), 32'd1);
    check("rst_domain",    32'(seq_if.domain_reset), 32'd1);
    check("rst_ready",     32'(seq_if.ready), 32'd0);
    check("rst_fault",     32'(seq_if.fault), 32'd0);
    check("rst_retry",     32'(seq_if.retry_count), 32'd0);
    check("rst_loss",      32'(seq_if.loss_count), 32'd0);
    check("rst_state",     32'(seq_if.state), 32'd0);
    check("rst_led",       32'(seq_if.led), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    check_reset_state();
    reset = 1'b0;
  endtask

  task automatic run_loss();
    seq_if.pll_locked = 1'b0;
    tick(2);
    check("loss_ready_hold", 32'(seq_if.ready), 32'd1);
    tick(1);
    check("loss_ready_fall", 32'(seq_if.ready), 32'd0);
    check("loss_domain",     32'(seq_if.domain_reset), 32'd1);
    check("loss_state",      32'(seq_if.state), 32'd0);
    seq_if.pll_locked = 1'b1;
    tick(12);
    check("reseq_not_ready", 32'(seq_if.ready), 32'd0);
    tick(1);
    check("reseq_ready",     32'(seq_if.ready), 32'd1);
  endtask

  initial begin
    logic led_a;
    seq_if.pll_locked = 1'b0;

    // Normal bring-up: lock rises at cycle 6, ready expected at cycle 17.
    do_reset();
    check("bu_pll_reset_c0", 32'(seq_if.pll_reset), 32'd1);
    tick(3);
    check("bu_pll_reset_c3", 32'(seq_if.pll_reset), 32'd1);
    tick(1);
    check("bu_pll_reset_c4", 32'(seq_if.pll_reset), 32'd0);
    check("bu_state_c4",     32'(seq_if.state), 32'd1);
    tick(2);
    seq_if.pll_locked = 1'b1;
    tick(10);
    check("bu_state_c16",    32'(seq_if.state), 32'd2);
    check("bu_ready_c16",    32'(seq_if.ready), 32'd0);
    tick(1);
    check("bu_ready_c17",    32'(seq_if.ready), 32'd1);
    check("bu_domain_c17",   32'(seq_if.domain_reset), 32'd0);
    check("bu_state_c17",    32'(seq_if.state), 32'd3);
`ifdef PLL_LOCK_SEQUENCER_LED_EN
    check("led_run_on",      32'(seq_if.led), 32'd0);
`else
    check("led_off_run",     32'(seq_if.led), 32'd1);
`endif

    // Glitch in STABLE: one-cycle drop at cycle 10.
    seq_if.pll_locked = 1'b0;
    do_reset();
    tick(6);
    seq_if.pll_locked = 1'b1;
    tick(4);
    check("gl_state_c10",    32'(seq_if.state), 32'd2);
    seq_if.pll_locked = 1'b0;
    tick(1);
    seq_if.pll_locked = 1'b1;
    tick(2);
    check("gl_state_c13",    32'(seq_if.state), 32'd1);
    check("gl_retry_c13",    32'(seq_if.retry_count), 32'd0);
    tick(1);
    check("gl_state_c14",    32'(seq_if.state), 32'd2);
    tick(7);
    check("gl_ready_c21",    32'(seq_if.ready), 32'd0);
    tick(1);
    check("gl_ready_c22",    32'(seq_if.ready), 32'd1);

    // Three losses in RUN, then saturation of the loss counter.
    for (int i = 0; i < 3; i++) run_loss();
    check("loss_count_3",    32'(seq_if.loss_count), 32'd3);
    check("loss_retry_0",    32'(seq_if.retry_count), 32'd0);
    for (int i = 0; i < 252; i++) run_loss();
    check("loss_count_255",  32'(seq_if.loss_count), 32'd255);
    for (int i = 0; i < 5; i++) run_loss();
    check("loss_count_sat",  32'(seq_if.loss_count), 32'd255);

    // Timeout and retry with lock held low, ending in FAULT.
    seq_if.pll_locked = 1'b0;
    do_reset();
    tick(23);
    check("to_state_c23",    32'(seq_if.state), 32'd1);
    check("to_retry_c23",    32'(seq_if.retry_count), 32'd0);
    tick(1);
    check("to_state_c24",    32'(seq_if.state), 32'd0);
    check("to_retry_c24",    32'(seq_if.retry_count), 32'd1);
    check("to_pllrst_c24",   32'(seq_if.pll_reset), 32'd1);
    tick(4);
    check("to_state_c28",    32'(seq_if.state), 32'd1);
    tick(19);
    check("to_state_c47",    32'(seq_if.state), 32'd1);
    tick(1);
    check("to_state_fault",  32'(seq_if.state), 32'd4);
    check("to_fault",        32'(seq_if.fault), 32'd1);
    check("to_retry_2",      32'(seq_if.retry_count), 32'd2);
    check("to_pll_reset",    32'(seq_if.pll_reset), 32'd1);
    check("to_domain",       32'(seq_if.domain_reset), 32'd1);
    check("to_ready",        32'(seq_if.ready), 32'd0);

    // FAULT must hold for 100 cycles with lock back.
    seq_if.pll_locked = 1'b1;
    tick(50);
    led_a = seq_if.led;
    tick(8);
`ifdef PLL_LOCK_SEQUENCER_LED_EN
    check("led_fault_toggle", 32'(seq_if.led), 32'(~led_a));
    tick(8);
    check("led_fault_period", 32'(seq_if.led), 32'(led_a));
    tick(34);
`else
    check("led_off_fault",   32'(seq_if.led), 32'd1);
    tick(42);
`endif
    check("fault_hold_state", 32'(seq_if.state), 32'd4);
    check("fault_hold_flag",  32'(seq_if.fault), 32'd1);

    // Reset is the only way out of FAULT.
    reset = 1'b1;
    tick(1);
    check("fr_state",        32'(seq_if.state), 32'd0);
    check("fr_fault",        32'(seq_if.fault), 32'd0);
    check("fr_retry",        32'(seq_if.retry_count), 32'd0);
    reset = 1'b0;

`ifdef PLL_LOCK_SEQUENCER_LED_EN
    // Slow blink while sequencing.
    seq_if.pll_locked = 1'b0;
    tick(2);
    led_a = seq_if.led;
    tick(8);
    check("led_seq_toggle",  32'(seq_if.led), 32'(~led_a));
`else
    tick(2);
    check("led_off_seq",     32'(seq_if.led), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Supervises the on-chip PLL from the always-running 27 MHz `ext_clk` domain: pulses the PLL reset, waits for lock with timeout and retry, qualifies lock stability, then releases the reset of the PLL-clocked logic (e.g. the 75 MHz blinker). Loss of lock during operation re-asserts the domain reset and restarts the sequence. Persistent lock failure ends in a sticky fault.

## Interface
- `RESET_CYCLES`, 27: PLL reset pulse width in `ext_clk` cycles (1 µs).
- `LOCK_TIMEOUT`, 270_000: max cycles to wait for lock per attempt (10 ms).
- `STABLE_CYCLES`, 2_700: cycles lock must stay continuously high before release (100 µs).
- `MAX_RETRIES`, 7: failed attempts tolerated before FAULT; range 1..15.
- `ext_clk` input 1: 27 MHz reference clock; the only clock.
- `reset` input 1: synchronous, active-high.
- `pll_locked` input 1: PLL lock flag, asynchronous to `ext_clk`.
- `pll_reset` output 1: PLL reset, active-high.
- `domain_reset` output 1: reset for PLL-clocked logic, active-high. The consumer re-synchronises it into its own domain.
- `ready` output 1: high only in RUN.
- `fault` output 1: sticky high in FAULT.
- `retry_count` output 4: failed attempts in the current sequence.
- `loss_count` output 8: lock losses seen in RUN; saturates at 255.
- `state` output 3: current state encoding, for debug.
- `led` output 1: status LED, active low.

## Operation
- `pll_locked` passes through a 2-FF synchroniser; all logic uses the synchronised `lock_s`.
- Every state has one down-counter of width `$clog2(LOCK_TIMEOUT+1)`. The counter is loaded on state entry.
- States and transitions:
  - PLL_RST (0): `pll_reset=1`, `domain_reset=1`. After RESET_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK (1): `pll_reset=0`.
    - `lock_s=1`: go to STABLE.
    - Counter expires without lock: `retry_count++`. If `retry_count` reaches MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
  - STABLE (2): if `lock_s` drops, go back to WAIT_LOCK (no retry charged; the timeout counter reloads). After STABLE_CYCLES cycles of continuous lock, go to RUN.
  - RUN (3): `domain_reset=0`, `ready=1`, `retry_count` cleared on entry. If `lock_s=0`, `loss_count++` (saturating), `domain_reset` asserts on that same edge, and the state goes to PLL_RST.
  - FAULT (4): `pll_reset=1`, `domain_reset=1`, `fault=1`. Exits only on `reset`.
- `domain_reset` is 0 only in RUN. `pll_reset` is 1 in PLL_RST and FAULT.
- Lock drop on the same cycle as the STABLE counter expiry: the drop wins, and the state returns to WAIT_LOCK.

## Timing
- After `reset`, all outputs are:
  - `pll_reset=1`, `domain_reset=1`
  - `ready=0`, `fault=0`
  - `retry_count=0`, `loss_count=0`
  - `state=PLL_RST`, `led=1`
- `reset` mid-sequence returns to PLL_RST on the next edge and clears both counts. It is the only exit from FAULT.
- `pll_locked` edge to `lock_s`: 2 cycles.
- Minimum time from release of `reset` to `ready`: RESET_CYCLES + 2 + STABLE_CYCLES + 1 cycles.
- Lock loss in RUN: `ready` falls and `domain_reset` rises 3 cycles after `pll_locked` falls (2 synchroniser cycles + 1 registered cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PLL_LOCK_SEQUENCER_LED_EN` defined: `led` shows a blink pattern driven by a 24-bit free-running counter on `ext_clk`:
  - RUN: steady on (0).
  - PLL_RST / WAIT_LOCK / STABLE: toggles every 2^22 cycles (~3 Hz).
  - FAULT: toggles every 2^20 cycles (~13 Hz).
- Undefined: `led` is tied to 1 (off) and the blink counter is removed.

## Structure
- Shared package `pll_seq_pkg` holds:
  - the state enum (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4);
  - default timing constants;
  - the blink divider exponents.
- One sub-module, `sync2`: a 2-flop synchroniser for `pll_locked`, reusable elsewhere.

## Test plan
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Normal bring-up: release `reset`, raise `pll_locked` at cycle 6.
  - Required: `pll_reset` high for cycles 0–3; `ready` and `domain_reset=0` at cycle 6+2+8+1 = 17.
- Glitch in STABLE: lock drops for 1 cycle during STABLE.
  - Required: state returns to WAIT_LOCK; `retry_count` stays 0; `ready` is delayed by the full STABLE_CYCLES after lock recovers.
- Timeout and retry: `pll_locked` held 0.
  - Required: `retry_count=1` after the first 20-cycle wait, PLL_RST repeats, then FAULT with `fault=1`.
  - FAULT persists 100 cycles even after lock returns; `reset` clears it.
- Loss in RUN: drop lock 3 times while in RUN.
  - Required: `ready` falls 3 cycles after each drop; `loss_count` reads 3; full re-sequence each time.
- Saturation: force 260 losses.
  - Required: `loss_count` holds 255.
- LED (macro defined): check the blink half-period per state with the divider exponents overridden to 3; with the macro undefined, `led` stays 1.
